// File: rtl/layer1_ctrl.sv
// Sequencer for the LeNet layer-1 engine: loads 25 packed weight words, streams a
// 28x28 image, collects pooled outputs into the layer-2 buffer and reports done/err.
`timescale 1ns/1ps

module layer1_ctrl #(
    parameter int KERNEL_TAPS   = 25,
    parameter int IMG_PIXELS    = 784,
    parameter int POOL_OUTS     = 144,
    parameter int WADDR_W       = 5,
    parameter int IADDR_W       = 10,
    parameter int OADDR_W       = 8,
    parameter int DRAIN_TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               w_rd_en,
    output logic [WADDR_W-1:0] w_addr,
    input  logic [95:0]        w_data,
    output logic               img_rd_en,
    output logic [IADDR_W-1:0] img_addr,
    input  logic [15:0]        img_data,
    output logic [95:0]        l1_weights,
    output logic               l1_wen,
    output logic [15:0]        l1_datain,
    output logic               l1_enable,
    input  logic [95:0]        l1_dout,
    input  logic [5:0]         l1_out,
    input  logic [5:0]         l1_finish,
    output logic               ob_wr_en,
    output logic [OADDR_W-1:0] ob_addr,
    output logic [95:0]        ob_data
);

    localparam int NCH    = 6;
    localparam int DCNT_W = $clog2(DRAIN_TIMEOUT);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_W = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [IADDR_W-1:0] LAST_TAP  = IADDR_W'(KERNEL_TAPS - 1);
    localparam logic [IADDR_W-1:0] LAST_PIX  = IADDR_W'(IMG_PIXELS - 1);
    localparam logic [OADDR_W:0]   OUT_FULL  = (OADDR_W + 1)'(POOL_OUTS);
    localparam logic [DCNT_W-1:0]  DCNT_LAST = DCNT_W'(DRAIN_TIMEOUT - 1);

    logic [2:0]         state_reg, state_next;
    logic [IADDR_W-1:0] addr_reg;
    logic [OADDR_W:0]   ocnt_reg;
    logic [DCNT_W-1:0]  dcnt_reg;
    logic [NCH-1:0]     fin_reg;
    logic               err_reg;
    logic               l1_wen_reg, l1_enable_reg;
    logic               ob_wr_en_reg;
    logic [OADDR_W-1:0] ob_addr_reg;
    logic [95:0]        ob_data_reg;

    logic               accept;
    logic               capture;
    logic               out_pulse, out_full, wr_ok, lockstep_bad;
    logic [OADDR_W:0]   ocnt_after;
    logic [NCH-1:0]     fin_now;
    logic               all_fin, drain_exit_ok, drain_expired, err_set;

    assign accept    = (state_reg == S_IDLE) && start;
    assign capture   = (state_reg == S_STREAM) || (state_reg == S_DRAIN);
    assign out_pulse = capture && l1_out[NCH-1];
    assign out_full  = (ocnt_reg == OUT_FULL);
    assign wr_ok     = out_pulse && !out_full;
    assign lockstep_bad = capture && (l1_out != '0) && (l1_out != '1);
    assign ocnt_after   = ocnt_reg + {{OADDR_W{1'b0}}, wr_ok};

    // Finish bits seen this cycle count immediately, so an exit coincides with the last write.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_fin
            assign fin_now[gi] = fin_reg[gi] | (capture & l1_finish[gi]);
        end
    endgenerate

    assign all_fin       = &fin_now;
    assign drain_exit_ok = (state_reg == S_DRAIN) && all_fin;
    assign drain_expired = (state_reg == S_DRAIN) && !all_fin && (dcnt_reg == DCNT_LAST);
    assign err_set       = lockstep_bad || (out_pulse && out_full) || drain_expired ||
                           (drain_exit_ok && (ocnt_after != OUT_FULL));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (start) state_next = S_LOAD_W;
            S_LOAD_W: if (addr_reg == LAST_TAP) state_next = S_STREAM;
            S_STREAM: if (addr_reg == LAST_PIX) state_next = S_DRAIN;
            S_DRAIN:  if (drain_exit_ok || drain_expired) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            addr_reg      <= '0;
            ocnt_reg      <= '0;
            dcnt_reg      <= '0;
            fin_reg       <= '0;
            err_reg       <= 1'b0;
            l1_wen_reg    <= 1'b0;
            l1_enable_reg <= 1'b0;
            ob_wr_en_reg  <= 1'b0;
            ob_addr_reg   <= '0;
            ob_data_reg   <= '0;
        end else begin
            state_reg <= state_next;

            // One address counter serves both the tap and the pixel sweep.
            if ((state_reg == S_LOAD_W || state_reg == S_STREAM) && state_next == state_reg)
                addr_reg <= addr_reg + 1'b1;
            else
                addr_reg <= '0;

            if (state_reg == S_DRAIN)
                dcnt_reg <= dcnt_reg + 1'b1;
            else
                dcnt_reg <= '0;

            if (accept) begin
                ocnt_reg <= '0;
                fin_reg  <= '0;
                err_reg  <= 1'b0;
            end else begin
                ocnt_reg <= ocnt_after;
                fin_reg  <= fin_now;
                if (err_set)
                    err_reg <= 1'b1;
            end

            l1_wen_reg    <= (state_reg == S_LOAD_W);
            l1_enable_reg <= (state_reg == S_STREAM);

            ob_wr_en_reg <= wr_ok;
            if (wr_ok) begin
                ob_addr_reg <= ocnt_reg[OADDR_W-1:0];
                ob_data_reg <= l1_dout;
            end
        end
    end

    assign busy      = (state_reg != S_IDLE);
    assign done      = (state_reg == S_DONE);
    assign err       = err_reg;
    assign w_rd_en   = (state_reg == S_LOAD_W);
    assign w_addr    = w_rd_en ? addr_reg[WADDR_W-1:0] : '0;
    assign img_rd_en = (state_reg == S_STREAM);
    assign img_addr  = img_rd_en ? addr_reg : '0;
    // Memory read data lands in the strobe cycle; gate so idle outputs stay at zero.
    assign l1_wen     = l1_wen_reg;
    assign l1_weights = l1_wen_reg ? w_data : '0;
    assign l1_enable  = l1_enable_reg;
    assign l1_datain  = l1_enable_reg ? img_data : '0;
    assign ob_wr_en   = ob_wr_en_reg;
    assign ob_addr    = ob_addr_reg;
    assign ob_data    = ob_data_reg;

endmodule
